// File: rtl/pcss_inf_pkg.sv
// Shared types and helpers for the PCSS link bridge.
//   calc_ratio  : host words per link flit count
//   calc_idx_w  : flit index register width
//   send_state_e: send FSM states
//   even_par    : even parity of a (zero-extended) flit
package pcss_inf_pkg;

    localparam int unsigned PAR_MAX_W = 256;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } send_state_e;

    function automatic int unsigned calc_ratio(input int unsigned data_w, input int unsigned flit_w);
        return data_w / flit_w;
    endfunction

    function automatic int unsigned calc_idx_w(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Zero-extension does not change parity, so one wide argument serves any flit width.
    function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/pcss_tik_gen.sv
// Programmable time-step pulse generator.
//   clk, rst       : clock, async active-high reset
//   tik_en_i       : enable; low clears the phase counter and holds tik_cnt_o
//   tik_period_i   : cycles per tik, 0 disables pulses
//   tik_o          : one-cycle pulse every tik_period_i cycles
//   tik_cnt_o      : number of pulses issued, wraps
module pcss_tik_gen #(
    parameter int unsigned TIK_PERIOD_W = 16,
    parameter int unsigned TIK_CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tik_en_i,
    input  logic [TIK_PERIOD_W-1:0] tik_period_i,
    output logic                    tik_o,
    output logic [TIK_CNT_W-1:0]    tik_cnt_o
);

    logic [TIK_PERIOD_W-1:0] cnt_q, cnt_d;
    logic                    tik_q, tik_d;
    logic [TIK_CNT_W-1:0]    tik_cnt_q, tik_cnt_d;

    // Using >= lets a period shrunk below the current phase fire on the next cycle.
    always_comb begin
        cnt_d     = '0;
        tik_d     = 1'b0;
        tik_cnt_d = tik_cnt_q;
        if (tik_en_i && (tik_period_i != '0)) begin
            if (cnt_q >= (tik_period_i - TIK_PERIOD_W'(1))) begin
                tik_d     = 1'b1;
                tik_cnt_d = tik_cnt_q + TIK_CNT_W'(1);
            end else begin
                cnt_d = cnt_q + TIK_PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            tik_q     <= 1'b0;
            tik_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            tik_q     <= tik_d;
            tik_cnt_q <= tik_cnt_d;
        end
    end

    assign tik_o     = tik_q;
    assign tik_cnt_o = tik_cnt_q;

endmodule

// File: rtl/pcss_link_bridge.sv
// Bridge between a host AXI-stream pair and one PCSS chip link port.
//   s_axis_*        : host words to send, split MSB-slice first into flits
//   send_data_*     : flits to chip with even parity; err+ready forces a resend
//   recv_data_*     : flits from chip, parity-checked and reassembled
//   m_axis_*        : reassembled host words, tlast marks an all-ones word
//   tik_*           : programmable time-step pulse and its wrap counter
//   err_cnt         : saturating count of send retries
module pcss_link_bridge
    import pcss_inf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned CHIPDATA_WIDTH = 16,
    parameter int unsigned TIK_PERIOD_W   = 16,
    parameter int unsigned TIK_CNT_W      = 8,
    parameter int unsigned ERR_CNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    output logic [CHIPDATA_WIDTH-1:0] send_data_out,
    output logic                      send_data_valid,
    output logic                      send_data_par,
    input  logic                      send_data_ready,
    input  logic                      send_data_err,
    input  logic [CHIPDATA_WIDTH-1:0] recv_data_in,
    input  logic                      recv_data_valid,
    input  logic                      recv_data_par,
    output logic                      recv_data_ready,
    output logic                      recv_data_err,
    input  logic                      tik_en,
    input  logic [TIK_PERIOD_W-1:0]   tik_period,
    output logic                      tik,
    output logic [TIK_CNT_W-1:0]      tik_cnt,
    output logic [ERR_CNT_W-1:0]      err_cnt
);

    localparam int unsigned RATIO = calc_ratio(DATA_WIDTH, CHIPDATA_WIDTH);
    localparam int unsigned IDX_W = calc_idx_w(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    // ---------------- send path ----------------
    send_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0]  tx_sh_q, tx_sh_d;
    logic [IDX_W-1:0]       tx_idx_q, tx_idx_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                   tx_fire_c, tx_retry_c;

    assign tx_fire_c  = (state_q == ST_SEND) && send_data_ready && !send_data_err;
    assign tx_retry_c = (state_q == ST_SEND) && send_data_ready &&  send_data_err;

    // Send FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Send FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (s_axis_tvalid) state_d = ST_SEND;
            ST_SEND: if (tx_fire_c && (tx_idx_q == LAST_IDX)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Send FSM outputs
    always_comb begin
        s_axis_tready   = 1'b0;
        send_data_valid = 1'b0;
        case (state_q)
            ST_IDLE: s_axis_tready   = 1'b1;
            ST_SEND: send_data_valid = 1'b1;
            default: ;
        endcase
    end

    // Send datapath: the current flit is always the top slice of the shift register
    always_comb begin
        tx_sh_d   = tx_sh_q;
        tx_idx_d  = tx_idx_q;
        err_cnt_d = err_cnt_q;
        if ((state_q == ST_IDLE) && s_axis_tvalid) begin
            tx_sh_d  = s_axis_tdata;
            tx_idx_d = '0;
        end
        if (tx_fire_c) begin
            tx_sh_d  = tx_sh_q << CHIPDATA_WIDTH;
            tx_idx_d = tx_idx_q + IDX_W'(1);
        end
        if (tx_retry_c && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sh_q   <= '0;
            tx_idx_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            tx_sh_q   <= tx_sh_d;
            tx_idx_q  <= tx_idx_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign send_data_out = tx_sh_q[DATA_WIDTH-1 -: CHIPDATA_WIDTH];
    assign send_data_par = even_par(PAR_MAX_W'(send_data_out));
    assign err_cnt       = err_cnt_q;

    // ---------------- receive path ----------------
    logic [IDX_W-1:0]      rx_idx_q, rx_idx_d;
    logic [DATA_WIDTH-1:0] rx_asm_q, rx_asm_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  rx_err_q, rx_err_d;
    logic                  rx_accept_c, rx_par_bad_c;
    logic [DATA_WIDTH-1:0] rx_asm_next_c;

    // Only the completing flit needs a free output register; earlier flits always flow.
    assign recv_data_ready = !((rx_idx_q == LAST_IDX) && out_valid_q);
    assign rx_accept_c     = recv_data_valid && recv_data_ready;
    assign rx_par_bad_c    = even_par(PAR_MAX_W'(recv_data_in)) != recv_data_par;
    assign rx_asm_next_c   = (rx_asm_q << CHIPDATA_WIDTH) | DATA_WIDTH'(recv_data_in);

    always_comb begin
        rx_idx_d    = rx_idx_q;
        rx_asm_d    = rx_asm_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        rx_err_d    = 1'b0;
        if (out_valid_q && m_axis_tready) out_valid_d = 1'b0;
        if (rx_accept_c) begin
            if (rx_par_bad_c) begin
                rx_err_d = 1'b1;
            end else begin
                rx_asm_d = rx_asm_next_c;
                if (rx_idx_q == LAST_IDX) begin
                    out_d       = rx_asm_next_c;
                    out_valid_d = 1'b1;
                    out_last_d  = &rx_asm_next_c;
                    rx_idx_d    = '0;
                end else begin
                    rx_idx_d = rx_idx_q + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_idx_q    <= '0;
            rx_asm_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            rx_err_q    <= 1'b0;
        end else begin
            rx_idx_q    <= rx_idx_d;
            rx_asm_q    <= rx_asm_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            rx_err_q    <= rx_err_d;
        end
    end

    assign m_axis_tdata  = out_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;
    assign recv_data_err = rx_err_q;

    // ---------------- tik generator ----------------
    pcss_tik_gen #(
        .TIK_PERIOD_W (TIK_PERIOD_W),
        .TIK_CNT_W    (TIK_CNT_W)
    ) u_tik_gen (
        .clk          (clk),
        .rst          (rst),
        .tik_en_i     (tik_en),
        .tik_period_i (tik_period),
        .tik_o        (tik),
        .tik_cnt_o    (tik_cnt)
    );

endmodule

// File: tb/tb_pcss_link_bridge.sv
// Directed bench for pcss_link_bridge (64-bit words, 16-bit flits).
module tb_pcss_link_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [15:0] send_data_out;
    logic        send_data_valid;
    logic        send_data_par;
    logic        send_data_ready;
    logic        send_data_err;
    logic [15:0] recv_data_in;
    logic        recv_data_valid;
    logic        recv_data_par;
    logic        recv_data_ready;
    logic        recv_data_err;
    logic        tik_en;
    logic [15:0] tik_period;
    logic        tik;
    logic [7:0]  tik_cnt;
    logic [7:0]  err_cnt;

    pcss_link_bridge dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .send_data_out   (send_data_out),
        .send_data_valid (send_data_valid),
        .send_data_par   (send_data_par),
        .send_data_ready (send_data_ready),
        .send_data_err   (send_data_err),
        .recv_data_in    (recv_data_in),
        .recv_data_valid (recv_data_valid),
        .recv_data_par   (recv_data_par),
        .recv_data_ready (recv_data_ready),
        .recv_data_err   (recv_data_err),
        .tik_en          (tik_en),
        .tik_period      (tik_period),
        .tik             (tik),
        .tik_cnt         (tik_cnt),
        .err_cnt         (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]      word;
        logic [3:0][15:0] flit;
        logic [3:0]       par;
        logic             last;
    } vec_t;

    vec_t vecs[5];
    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [63:0] w,
                           input logic [15:0] f0, input logic [15:0] f1,
                           input logic [15:0] f2, input logic [15:0] f3,
                           input logic p0, input logic p1, input logic p2, input logic p3,
                           input logic last);
        vecs[i].word    = w;
        vecs[i].flit[0] = f0;
        vecs[i].flit[1] = f1;
        vecs[i].flit[2] = f2;
        vecs[i].flit[3] = f3;
        vecs[i].par[0]  = p0;
        vecs[i].par[1]  = p1;
        vecs[i].par[2]  = p2;
        vecs[i].par[3]  = p3;
        vecs[i].last    = last;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_tready"},  64'(s_axis_tready),   64'd1);
        check({tag, "_r_ready"},   64'(recv_data_ready), 64'd1);
        check({tag, "_snd_valid"}, 64'(send_data_valid), 64'd0);
        check({tag, "_m_tvalid"},  64'(m_axis_tvalid),   64'd0);
        check({tag, "_m_tlast"},   64'(m_axis_tlast),    64'd0);
        check({tag, "_r_err"},     64'(recv_data_err),   64'd0);
        check({tag, "_tik"},       64'(tik),             64'd0);
        check({tag, "_tik_cnt"},   64'(tik_cnt),         64'd0);
        check({tag, "_err_cnt"},   64'(err_cnt),         64'd0);
    endtask

    // Sends one word with send_data_ready high; err is held for err_len cycles on flit err_at.
    task automatic send_word(input vec_t v, input int err_at, input int err_len, input string tag);
        int t = 0;
        while (!s_axis_tready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_tready_in"}, 64'(s_axis_tready), 64'd1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = v.word;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_valid%0d", tag, i), 64'(send_data_valid), 64'd1);
            check($sformatf("%s_flit%0d", tag, i),  64'(send_data_out),   64'(v.flit[i]));
            check($sformatf("%s_par%0d", tag, i),   64'(send_data_par),   64'(v.par[i]));
            if (i == err_at) begin
                send_data_err = 1'b1;
                repeat (err_len) @(negedge clk);
                send_data_err = 1'b0;
                exp_err = (exp_err + err_len > 255) ? 255 : exp_err + err_len;
                check($sformatf("%s_resend%0d", tag, i), 64'(send_data_out), 64'(v.flit[i]));
                check($sformatf("%s_errcnt", tag),       64'(err_cnt),       64'(exp_err));
            end
            @(negedge clk);
        end
        check({tag, "_tready_back"}, 64'(s_axis_tready),   64'd1);
        check({tag, "_valid_off"},   64'(send_data_valid), 64'd0);
    endtask

    // Drives four flits back to back and checks the reassembled word one cycle later.
    task automatic recv_word(input vec_t v, input string tag);
        for (int i = 0; i < 4; i++) begin
            recv_data_valid = 1'b1;
            recv_data_in    = v.flit[i];
            recv_data_par   = v.par[i];
            @(negedge clk);
        end
        recv_data_valid = 1'b0;
        check({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd1);
        check({tag, "_m_tdata"},  m_axis_tdata,       v.word);
        check({tag, "_m_tlast"},  64'(m_axis_tlast),  64'(v.last));
        check({tag, "_r_err"},    64'(recv_data_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int tiks;

        set_vec(0, 64'h0123_4567_89AB_CDEF, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_vec(1, 64'hFFFF_0000_8000_0001, 16'hFFFF, 16'h0000, 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        set_vec(2, 64'hDEAD_BEEF_0007_1000, 16'hDEAD, 16'hBEEF, 16'h0007, 16'h1000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        set_vec(3, 64'h0000_0000_0000_0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_vec(4, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        rst             = 1'b1;
        s_axis_tdata    = '0;
        s_axis_tvalid   = 1'b0;
        m_axis_tready   = 1'b1;
        send_data_ready = 1'b1;
        send_data_err   = 1'b0;
        recv_data_in    = '0;
        recv_data_valid = 1'b0;
        recv_data_par   = 1'b0;
        tik_en          = 1'b0;
        tik_period      = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;
        @(negedge clk);

        // Table of words through both directions
        for (int i = 0; i < 5; i++) begin
            send_word(vecs[i], -1, 0, $sformatf("tx%0d", i));
            recv_word(vecs[i], $sformatf("rx%0d", i));
        end
        @(negedge clk);

        // Single peer error on flit 2, then a long error burst that saturates err_cnt
        send_word(vecs[0], 2, 1, "retry1");
        send_word(vecs[2], 1, 300, "retry300");

        // Output register stall: all-ones word held, completing flit of the next word blocked
        m_axis_tready = 1'b0;
        recv_word(vecs[4], "stall_a");
        for (int i = 0; i < 3; i++) begin
            recv_data_valid = 1'b1;
            recv_data_in    = vecs[1].flit[i];
            recv_data_par   = vecs[1].par[i];
            @(negedge clk);
        end
        recv_data_in  = vecs[1].flit[3];
        recv_data_par = vecs[1].par[3];
        repeat (3) begin
            check("stall_ready", 64'(recv_data_ready), 64'd0);
            check("stall_hold",  m_axis_tdata,         vecs[4].word);
            check("stall_valid", 64'(m_axis_tvalid),   64'd1);
            @(negedge clk);
        end
        m_axis_tready = 1'b1;
        t = 0;
        while (!recv_data_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("stall_release", 64'(recv_data_ready), 64'd1);
        @(negedge clk);
        recv_data_valid = 1'b0;
        check("stall_b_valid", 64'(m_axis_tvalid), 64'd1);
        check("stall_b_data",  m_axis_tdata,       vecs[1].word);
        check("stall_b_last",  64'(m_axis_tlast),  64'd0);
        @(negedge clk);

        // Back-to-back bad parity flits are dropped and each reported
        recv_data_valid = 1'b1;
        recv_data_in    = 16'h0001;
        recv_data_par   = 1'b0;
        @(negedge clk);
        recv_data_in    = 16'h0003;
        recv_data_par   = 1'b1;
        check("perr_pulse1", 64'(recv_data_err), 64'd1);
        @(negedge clk);
        recv_data_valid = 1'b0;
        check("perr_pulse2", 64'(recv_data_err), 64'd1);
        check("perr_novalid", 64'(m_axis_tvalid), 64'd0);
        @(negedge clk);
        check("perr_clear", 64'(recv_data_err), 64'd0);
        recv_word(vecs[2], "perr_word");
        @(negedge clk);

        // Tik generator: period 5 for 52 cycles, then period 0, then period 1
        tik_period = 16'd5;
        tik_en     = 1'b1;
        tiks       = 0;
        repeat (52) begin
            @(negedge clk);
            if (tik) tiks++;
        end
        check("tik_p5_pulses", 64'(tiks),    64'd10);
        check("tik_p5_cnt",    64'(tik_cnt), 64'd10);
        tik_period = 16'd0;
        tiks       = 0;
        repeat (20) begin
            @(negedge clk);
            if (tik) tiks++;
        end
        check("tik_p0_pulses", 64'(tiks),    64'd0);
        check("tik_p0_cnt",    64'(tik_cnt), 64'd10);
        tik_period = 16'd1;
        tiks       = 0;
        repeat (8) begin
            @(negedge clk);
            if (tik) tiks++;
        end
        check("tik_p1_pulses", 64'(tiks),    64'd8);
        check("tik_p1_cnt",    64'(tik_cnt), 64'd18);
        tik_en = 1'b0;
        repeat (3) @(negedge clk);
        check("tik_off",      64'(tik),     64'd0);
        check("tik_off_cnt",  64'(tik_cnt), 64'd18);

        // Reset in the middle of a word on both paths
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = vecs[0].word;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            recv_data_valid = 1'b1;
            recv_data_in    = vecs[2].flit[i];
            recv_data_par   = vecs[2].par[i];
            @(negedge clk);
        end
        check("mid_sending", 64'(send_data_out), 64'(vecs[0].flit[2]));
        recv_data_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        exp_err = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_nopulse", 64'(m_axis_tvalid), 64'd0);
        send_word(vecs[1], -1, 0, "post_rst_tx");
        recv_word(vecs[1], "post_rst_rx");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
